// File: rtl/rgb_led_serialiser.sv
// Serialises 24-bit RGB words onto a WS2812-style single-wire LED line.
// One-word holding register lets consecutive words go out with no gap; a low latch period closes each frame.
module rgb_led_serialiser #(
  parameter int T0H          = 40,
  parameter int T0L          = 85,
  parameter int T1H          = 80,
  parameter int T1L          = 45,
  parameter int LATCH_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] rgb_in,
  input  logic        rgb_valid,
  output logic        rgb_ready,
  input  logic        enable,
  output logic        led_dout,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

  localparam logic [15:0] T0H_M1   = 16'(T0H - 1);
  localparam logic [15:0] T0L_M1   = 16'(T0L - 1);
  localparam logic [15:0] T1H_M1   = 16'(T1H - 1);
  localparam logic [15:0] T1L_M1   = 16'(T1L - 1);
  localparam logic [15:0] LATCH_M1 = 16'(LATCH_CYCLES - 1);

  state_t      state;
  logic [23:0] hold;
  logic        hold_full;
  logic [23:0] shifter;
  logic [4:0]  bit_cnt;
  logic [15:0] phase;
  logic        accept;
  logic        load;
  logic        hold_full_nxt;

  // LED expects green first, then red, then blue, each MSB first
  function automatic logic [23:0] wire_order(input logic [23:0] c);
    return {c[15:8], c[23:16], c[7:0]};
  endfunction

  function automatic logic [15:0] high_m1(input logic b);
    return b ? T1H_M1 : T0H_M1;
  endfunction

  function automatic logic [15:0] low_m1(input logic b);
    return b ? T1L_M1 : T0L_M1;
  endfunction

  assign accept = rgb_valid && !hold_full;
  assign load   = hold_full && enable &&
                  ((state == IDLE) || (state == LOW && phase == 16'd0 && bit_cnt == 5'd0));
  assign hold_full_nxt = accept || (hold_full && !load);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold       <= 24'd0;
      hold_full  <= 1'b0;
      shifter    <= 24'd0;
      bit_cnt    <= 5'd0;
      phase      <= 16'd0;
      led_dout   <= 1'b0;
      rgb_ready  <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (accept) hold <= rgb_in;
      hold_full <= hold_full_nxt;
      rgb_ready <= !hold_full_nxt;

      case (state)
        IDLE: begin
          if (load) begin
            shifter  <= wire_order(hold);
            bit_cnt  <= 5'd23;
            phase    <= high_m1(hold[15]);
            led_dout <= 1'b1;
            busy     <= 1'b1;
            state    <= HIGH;
          end
        end
        HIGH: begin
          if (phase == 16'd0) begin
            phase    <= low_m1(shifter[23]);
            led_dout <= 1'b0;
            state    <= LOW;
          end else begin
            phase <= phase - 16'd1;
          end
        end
        LOW: begin
          if (phase != 16'd0) begin
            phase <= phase - 16'd1;
          end else if (bit_cnt != 5'd0) begin
            shifter  <= {shifter[22:0], 1'b0};
            bit_cnt  <= bit_cnt - 5'd1;
            phase    <= high_m1(shifter[22]);
            led_dout <= 1'b1;
            state    <= HIGH;
          end else if (load) begin
            // next word follows immediately, no idle gap on the line
            shifter  <= wire_order(hold);
            bit_cnt  <= 5'd23;
            phase    <= high_m1(hold[15]);
            led_dout <= 1'b1;
            state    <= HIGH;
          end else begin
            phase <= LATCH_M1;
            state <= LATCH;
          end
        end
        LATCH: begin
          if (phase == 16'd0) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            phase <= phase - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_led_serialiser.sv
// Bench for rgb_led_serialiser: waveform-queue reference model compared every cycle,
// directed frame checks decoded from the wire, then randomized traffic.
module tb_rgb_led_serialiser;
  localparam int T0H = 2, T0L = 3, T1H = 3, T1L = 2, LC = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] rgb_in = 24'd0;
  logic        rgb_valid = 1'b0;
  logic        enable = 1'b1;
  logic        rgb_ready, led_dout, busy, frame_done;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  bit go = 1'b0;

  rgb_led_serialiser #(
    .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L), .LATCH_CYCLES(LC)
  ) dut (
    .clk(clk), .rst(rst), .rgb_in(rgb_in), .rgb_valid(rgb_valid), .rgb_ready(rgb_ready),
    .enable(enable), .led_dout(led_dout), .busy(busy), .frame_done(frame_done)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the line is a queue of per-cycle levels built from the bit timing rules.
  bit          q[$];
  int          mmode;  // 0 idle, 1 sending words, 2 latch
  logic        m_led, m_busy, m_fd, m_hfull, m_acc;
  logic [23:0] m_hold;

  task automatic push_word(input logic [23:0] c);
    logic [23:0] w;
    int h, l;
    w = {c[15:8], c[23:16], c[7:0]};
    for (int i = 23; i >= 0; i--) begin
      h = w[i] ? T1H : T0H;
      l = w[i] ? T1L : T0L;
      repeat (h) q.push_back(1'b1);
      repeat (l) q.push_back(1'b0);
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete(); mmode = 0; m_led = 0; m_busy = 0; m_fd = 0; m_hfull = 0;
    end else begin
      m_acc = rgb_valid && !m_hfull;
      m_fd  = 0;
      if (mmode == 1 && q.size() == 0) begin
        if (m_hfull && enable) begin push_word(m_hold); m_hfull = 0; end
        else begin repeat (LC) q.push_back(1'b0); mmode = 2; end
      end else if (mmode == 2 && q.size() == 0) begin
        m_fd = 1; mmode = 0;
      end else if (mmode == 0 && m_hfull && enable) begin
        push_word(m_hold); m_hfull = 0; mmode = 1;
      end
      m_led  = (q.size() > 0) ? q.pop_front() : 1'b0;
      m_busy = (mmode != 0);
      if (m_acc) begin m_hfull = 1; m_hold = rgb_in; end
    end
  end

  initial forever begin
    @(negedge clk);
    if (go) begin
      vectors++;
      if (led_dout !== m_led || busy !== m_busy || frame_done !== m_fd || rgb_ready !== !m_hfull) begin
        miscompares++;
        $display("FAIL cycle %0d led/busy/fd/ready: got %b%b%b%b expected %b%b%b%b", cyc,
                 led_dout, busy, frame_done, rgb_ready, m_led, m_busy, m_fd, !m_hfull);
      end
    end
  end

  // Wire decoder: pulse width -> bit, plus frame/rise timestamps
  bit dec[$];
  int hi_len = 0, rise_cyc = 0, fd_cnt = 0;
  bit prev = 0, arm = 0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      hi_len = 0; prev = 0;
    end else begin
      if (led_dout === 1'b1) hi_len++;
      else if (prev) begin dec.push_back(hi_len == T1H); hi_len = 0; end
      if (led_dout === 1'b1 && !prev && arm) begin rise_cyc = cyc; arm = 0; end
      if (frame_done === 1'b1) fd_cnt++;
      prev = (led_dout === 1'b1);
    end
  end

  function automatic logic [23:0] pack(input int off);
    logic [23:0] w;
    w = 24'd0;
    if (off + 24 <= dec.size())
      for (int i = 0; i < 24; i++) w = {w[22:0], dec[off + i]};
    return w;
  endfunction

  task automatic send(input logic [23:0] word);
    bit acc;
    int n;
    n = 0;
    rgb_in = word; rgb_valid = 1'b1;
    forever begin
      acc = (rgb_ready === 1'b1);
      @(posedge clk); @(negedge clk);
      if (acc) break;
      n++;
      if (n > 400) begin check("send_timeout", 0, 1); break; end
    end
    rgb_valid = 1'b0;
  endtask

  task automatic wait_fd(output int t);
    int n;
    n = 0; t = 0;
    while (frame_done !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    if (frame_done === 1'b1) t = cyc;
    else check("frame_done_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    int t, t1, t2, hi;
    bit acc;

    // async reset with no clock edge in between
    #2 rst = 1'b1;
    #1;
    check("rst_led", led_dout, 0);
    check("rst_ready", rgb_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fd", frame_done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0; go = 1'b1;
    @(negedge clk);

    // single word
    dec.delete(); fd_cnt = 0; arm = 1;
    send(24'hFF0000);
    wait_fd(t);
    check("t2_bits", dec.size(), 24);
    check("t2_word", pack(0), 24'h00FF00);
    check("t2_period", t - rise_cyc, 130);
    check("t2_fd_count", fd_cnt, 1);

    // back-to-back words; second held while ready is low
    dec.delete(); fd_cnt = 0; arm = 1;
    send(24'h00FF00);
    send(24'h0000FF);
    check("t3_ready_low", rgb_ready, 0);
    wait_fd(t);
    check("t3_bits", dec.size(), 48);
    check("t3_word0", pack(0), 24'hFF0000);
    check("t3_word1", pack(24), 24'h0000FF);
    check("t3_period", t - rise_cyc, 250);
    check("t3_fd_count", fd_cnt, 1);

    // word accepted during latch
    dec.delete(); fd_cnt = 0;
    send(24'hFF0000);
    repeat (124) @(negedge clk);
    send(24'h00FFFF);
    check("t4_ready_low", rgb_ready, 0);
    check("t4_line_low", led_dout, 0);
    check("t4_busy", busy, 1);
    arm = 1;
    wait_fd(t1);
    check("t4_fd_count1", fd_cnt, 1);
    wait_fd(t2);
    check("t4_restart", rise_cyc - t1, 1);
    check("t4_period", t2 - rise_cyc, 130);
    check("t4_word0", pack(0), 24'h00FF00);
    check("t4_word1", pack(24), 24'hFF00FF);
    check("t4_fd_count2", fd_cnt, 2);

    // reset during bit 10
    send(24'hFFFF00);
    repeat (52) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_led", led_dout, 0);
    check("t6_rst_ready", rgb_ready, 1);
    check("t6_rst_busy", busy, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    dec.delete(); arm = 1;
    send(24'hFFFF00);
    wait_fd(t);
    check("t6_bits", dec.size(), 24);
    check("t6_word", pack(0), 24'hFFFF00);
    check("t6_period", t - rise_cyc, 130);

    // enable low holds the word back
    enable = 1'b0;
    send(24'h123456);
    hi = 0;
    repeat (40) begin @(negedge clk); if (led_dout !== 1'b0) hi++; end
    check("t6_disabled_line", hi, 0);
    check("t6_disabled_busy", busy, 0);
    check("t6_disabled_ready", rgb_ready, 0);
    dec.delete(); enable = 1'b1;
    wait_fd(t);
    check("t6_held_word", pack(0), 24'h341256);

    // randomized traffic
    for (int c = 0; c < 15000; c++) begin
      acc = rgb_valid && (rgb_ready === 1'b1);
      @(posedge clk); @(negedge clk);
      if (acc) rgb_valid = 1'b0;
      if (!rgb_valid && $urandom_range(0, 99) < 30) begin
        rgb_valid = 1'b1;
        rgb_in = 24'($urandom);
      end
      if ($urandom_range(0, 199) == 0) enable = !enable;
    end
    rgb_valid = 1'b0; enable = 1'b1;
    repeat (700) @(negedge clk);
    check("drain_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
